eth_tx_scheduler: RTL
=====================

ETH_TX_SCHEDULER -- requirements
Module: eth_tx_scheduler

Interface
REQ-001 Parameter NUM_REQ, default 2, number of requesters sharing the frame transmitter (2..8).
REQ-002 Parameter IFG_CYCLES, default 48, inter-frame gap in clk cycles (96 bit times at 2 bits/cycle).
REQ-003 Parameter START_TIMEOUT, default 64, max cycles from pb_start to transmitter txen rising.
REQ-004 clk  in  1  Ethernet reference clock, all logic on rising edge.
REQ-005 rst_n  in  1  reset, asynchronous and active-low.
REQ-006 req  in  NUM_REQ  per-requester level request, held until matching ack.
REQ-007 req_data  in  NUM_REQ*16  per-requester 16-bit payload, slice i belongs to req[i].
REQ-008 req_dst_mac  in  NUM_REQ*48  per-requester destination MAC, slice i belongs to req[i].
REQ-009 ack  out  NUM_REQ  one-cycle pulse on bit i when requester i's frame has finished.
REQ-010 busy  out  1  high in every state except IDLE.
REQ-011 grant_id  out  $clog2(NUM_REQ)  index of requester currently owning the transmitter.
REQ-012 pb_start  out  1  one-cycle start pulse to the frame transmitter.
REQ-013 pb_data  out  16  payload to transmitter, stable from pb_start until return to IDLE.
REQ-014 pb_dst_mac  out  48  destination MAC to transmitter, same stability as pb_data.
REQ-015 pb_txen  in  1  transmitter txen, monitored to detect frame start/end.
REQ-016 timeout_err  out  1  one-cycle pulse when transmitter fails to start within START_TIMEOUT.

Function
REQ-017 FSM states SHALL be IDLE, START, WAIT_TX, BUSY, GAP.
REQ-018 IDLE: if any req bit high, winner chosen round-robin starting from (last_grant+1) mod NUM_REQ; winner's req_data/req_dst_mac latched into pb_data/pb_dst_mac, grant_id updated, next state START.
REQ-019 START: pb_start=1 for exactly this one cycle; next state WAIT_TX; latency req-high-in-IDLE to pb_start-high = 1 cycle.
REQ-020 WAIT_TX: cycle counter increments; pb_txen=1 -> BUSY; counter reaching START_TIMEOUT with pb_txen=0 -> timeout_err pulse, no ack, next GAP, last_grant updated (requester retries later, no starvation of others).
REQ-021 BUSY: pb_txen falling (1 in previous cycle, 0 now) -> ack[grant_id] pulse same cycle as transition, last_grant=grant_id, next GAP.
REQ-022 GAP: counter counts IFG_CYCLES cycles, then IDLE; req ignored during GAP.
REQ-023 Requests are sampled only in IDLE; req changes during other states SHALL not affect the ongoing frame.
REQ-024 Requester dropping req after grant: frame still completes and ack still pulses.
REQ-025 Simultaneous requests: exactly one grant; with all req held high, grants SHALL rotate 0,1,...,NUM_REQ-1,0.
REQ-026 pb_txen high while in IDLE/GAP SHALL be ignored.
REQ-027 At most one ack bit high in any cycle; ack and timeout_err never high in the same cycle.
REQ-028 Counters SHALL be sized to hold max(IFG_CYCLES, START_TIMEOUT) without wrap.

Reset
REQ-029 rst_n low SHALL immediately force state IDLE, pb_start 0, pb_data 0, pb_dst_mac 0, ack 0, busy 0, grant_id 0, timeout_err 0, counters 0, last_grant NUM_REQ-1 (so requester 0 wins first).
REQ-030 Reset mid-frame SHALL abort without ack; no pb_start re-issued until a fresh IDLE grant.

Structure
REQ-031 Package eth_tx_pkg SHALL hold the state enum, MAC_W=48, DATA_W=16 and default IFG_CYCLES constant.
REQ-032 Round-robin selection SHALL live in one sub-module rr_arbiter (req, last_grant in; valid, grant index out, combinational).

Verification
REQ-033 Single request: req[0]=1, data 16'h5678, dst FF..FF, model txen high 40 cycles after 2-cycle delay -> pb_start 1 cycle after req, pb_data=16'h5678, ack[0] on txen fall, busy low exactly 48 cycles later.
REQ-034 Contention: req=2'b11 held, data0=16'h1111, data1=16'h2222 -> frames in order 1111, 2222, 1111; each pair separated by >=48 idle cycles.
REQ-035 Timeout: req[1]=1, txen held 0 -> timeout_err pulse 64 cycles after pb_start, no ack, then req[0] served first if pending.
REQ-036 Mid-frame reset: assert rst_n=0 during BUSY -> all outputs zero same cycle, no ack; after release req[0] re-granted with new pb_start.
REQ-037 Request withdrawal: req[0] dropped 3 cycles after pb_start -> frame continues, ack[0] still pulses, pb_data unchanged throughout.

Source files
------------

// File: rtl/eth_tx_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : eth_tx_pkg
//  Purpose  : Shared types and constants for the Ethernet TX scheduler.
//             Holds the scheduler state encoding, the payload/MAC widths,
//             the default inter-frame gap, and a small sizing helper.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package eth_tx_pkg;

   localparam int MAC_W              = 48;
   localparam int DATA_W             = 16;
   // 96 bit times at 2 bits per clock
   localparam int IFG_CYCLES_DEFAULT = 48;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      START   = 3'd1,
      WAIT_TX = 3'd2,
      BUSY    = 3'd3,
      GAP     = 3'd4
   } tx_state_t;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage
`default_nettype wire

// File: rtl/eth_tx_scheduler_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : rr_arbiter
//  Purpose  : Combinational round-robin pick. The search starts at
//             (last_grant + 1) mod NUM_REQ and wraps around; the first
//             requester found wins.
//  Ports    : req        in  NUM_REQ  request vector
//             last_grant in  IDX_W    index granted most recently
//             valid      out 1        at least one request present
//             grant      out IDX_W    winning index (0 when valid is low)
//  Revision : 1.0  initial release
// ============================================================================
module rr_arbiter #(
   parameter int NUM_REQ = 2,
   parameter int IDX_W   = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   last_grant,
   output logic               valid,
   output logic [IDX_W-1:0]   grant
);

   int w_dist;
   int w_best;

   // Each requester's distance from the slot just after last_grant; the
   // smallest distance among active requests is the round-robin winner.
   always_comb begin
      valid  = 1'b0;
      grant  = '0;
      w_dist = 0;
      w_best = NUM_REQ;
      for (int i = 0; i < NUM_REQ; i++) begin
         w_dist = (i + NUM_REQ - int'(last_grant) - 1) % NUM_REQ;
         if (req[i] && (w_dist < w_best)) begin
            w_best = w_dist;
            grant  = IDX_W'(i);
            valid  = 1'b1;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/eth_tx_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : eth_tx_scheduler
//  Purpose  : Shares one Ethernet frame transmitter between NUM_REQ
//             requesters. Picks a requester round-robin in IDLE, latches its
//             payload and destination MAC, pulses pb_start, follows the
//             transmitter's txen to detect frame start/end, acks the
//             requester and enforces the inter-frame gap.
//  Ports    : clk          in  1             rising-edge clock
//             rst_n        in  1             async active-low reset
//             req          in  NUM_REQ       level requests
//             req_data     in  NUM_REQ*16    per-requester payload
//             req_dst_mac  in  NUM_REQ*48    per-requester destination MAC
//             ack          out NUM_REQ       frame-done pulse
//             busy         out 1             not in IDLE
//             grant_id     out clog2(NUM_REQ) current owner
//             pb_start     out 1             start pulse to transmitter
//             pb_data      out 16            latched payload
//             pb_dst_mac   out 48            latched destination MAC
//             pb_txen      in  1             transmitter txen
//             timeout_err  out 1             transmitter never started
//  Revision : 1.0  initial release
// ============================================================================
module eth_tx_scheduler
   import eth_tx_pkg::*;
#(
   parameter int NUM_REQ       = 2,
   parameter int IFG_CYCLES    = IFG_CYCLES_DEFAULT,
   parameter int START_TIMEOUT = 64
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic [NUM_REQ-1:0]          req,
   input  logic [NUM_REQ*DATA_W-1:0]   req_data,
   input  logic [NUM_REQ*MAC_W-1:0]    req_dst_mac,
   output logic [NUM_REQ-1:0]          ack,
   output logic                        busy,
   output logic [$clog2(NUM_REQ)-1:0]  grant_id,
   output logic                        pb_start,
   output logic [DATA_W-1:0]           pb_data,
   output logic [MAC_W-1:0]            pb_dst_mac,
   input  logic                        pb_txen,
   output logic                        timeout_err
);

   localparam int c_idx_w = $clog2(NUM_REQ);
   localparam int c_cnt_w = $clog2(max_int(IFG_CYCLES, START_TIMEOUT) + 1);

   tx_state_t             r_state;
   tx_state_t             w_state_nxt;
   logic [c_cnt_w-1:0]    r_cnt;
   logic [c_cnt_w-1:0]    w_cnt_nxt;
   logic                  r_txen_q;
   logic [c_idx_w-1:0]    r_grant_id;
   logic [c_idx_w-1:0]    r_last_grant;
   logic [c_idx_w-1:0]    w_last_grant_nxt;
   logic [DATA_W-1:0]     r_pb_data;
   logic [MAC_W-1:0]      r_pb_mac;
   logic                  w_load;
   logic                  w_ack_fire;
   logic                  w_arb_valid;
   logic [c_idx_w-1:0]    w_arb_grant;
   logic [DATA_W-1:0]     w_sel_data;
   logic [MAC_W-1:0]      w_sel_mac;

   rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (c_idx_w)
   ) u_arb (
      .req        (req),
      .last_grant (r_last_grant),
      .valid      (w_arb_valid),
      .grant      (w_arb_grant)
   );

   // Winner's payload/MAC slice
   always_comb begin
      w_sel_data = '0;
      w_sel_mac  = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (w_arb_grant == c_idx_w'(i)) begin
            w_sel_data = req_data[i*DATA_W +: DATA_W];
            w_sel_mac  = req_dst_mac[i*MAC_W +: MAC_W];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= IDLE;
         r_cnt        <= '0;
         r_txen_q     <= 1'b0;
         r_grant_id   <= '0;
         r_last_grant <= c_idx_w'(NUM_REQ - 1);
         r_pb_data    <= '0;
         r_pb_mac     <= '0;
      end else begin
         r_state      <= w_state_nxt;
         r_cnt        <= w_cnt_nxt;
         r_txen_q     <= pb_txen;
         r_last_grant <= w_last_grant_nxt;
         if (w_load) begin
            r_grant_id <= w_arb_grant;
            r_pb_data  <= w_sel_data;
            r_pb_mac   <= w_sel_mac;
         end
      end
   end

   // The counter is loaded with 1 on entry to WAIT_TX and GAP so that its
   // value equals the number of cycles spent since pb_start (WAIT_TX) or
   // since the ack/timeout cycle (GAP).
   always_comb begin
      w_state_nxt      = r_state;
      w_cnt_nxt        = r_cnt;
      w_last_grant_nxt = r_last_grant;
      w_load           = 1'b0;
      w_ack_fire       = 1'b0;
      pb_start         = 1'b0;
      timeout_err      = 1'b0;
      case (r_state)
         IDLE: begin
            w_cnt_nxt = '0;
            if (w_arb_valid) begin
               w_load      = 1'b1;
               w_state_nxt = START;
            end
         end
         START: begin
            pb_start    = 1'b1;
            w_cnt_nxt   = c_cnt_w'(1);
            w_state_nxt = WAIT_TX;
         end
         WAIT_TX: begin
            // txen arriving on the timeout cycle still counts as a start
            if (pb_txen) begin
               w_cnt_nxt   = '0;
               w_state_nxt = BUSY;
            end else if (r_cnt == c_cnt_w'(START_TIMEOUT)) begin
               timeout_err      = 1'b1;
               w_last_grant_nxt = r_grant_id;
               w_cnt_nxt        = c_cnt_w'(1);
               w_state_nxt      = GAP;
            end else begin
               w_cnt_nxt = r_cnt + c_cnt_w'(1);
            end
         end
         BUSY: begin
            if (r_txen_q && !pb_txen) begin
               w_ack_fire       = 1'b1;
               w_last_grant_nxt = r_grant_id;
               w_cnt_nxt        = c_cnt_w'(1);
               w_state_nxt      = GAP;
            end
         end
         GAP: begin
            if (r_cnt == c_cnt_w'(IFG_CYCLES)) begin
               w_cnt_nxt   = '0;
               w_state_nxt = IDLE;
            end else begin
               w_cnt_nxt = r_cnt + c_cnt_w'(1);
            end
         end
         default: begin
            w_cnt_nxt   = '0;
            w_state_nxt = IDLE;
         end
      endcase
   end

   always_comb begin
      ack = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         ack[i] = w_ack_fire && (r_grant_id == c_idx_w'(i));
      end
   end

   assign busy       = (r_state != IDLE);
   assign grant_id   = r_grant_id;
   assign pb_data    = r_pb_data;
   assign pb_dst_mac = r_pb_mac;

endmodule
`default_nettype wire
